// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and counter sizing.
package adder_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT,
    DONE  = ST_DONE
  } state_t;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder built from two half-adder cells with their carries ORed.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic c
);

  logic s0;
  logic c0;
  logic c1;

  halfadder u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  halfadder u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  assign c = c0 | c1;

endmodule

// File: rtl/halfadder.sv
// Half-adder cell: sum and carry of two single bits.
module halfadder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder with valid/ready operand and result handshakes.
// Defining SERIAL_ADDER_OVF_EN adds the signed-overflow output ovf.
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             cout_r;
  logic             s_bit;
  logic             c_bit;
  logic             last_bit;

  full_adder_bit u_fa (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (s_bit),
    .c   (c_bit)
  );

  assign last_bit = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake flags come straight from the state register, so no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == SHIFT);
  assign out_valid = (state == DONE);
  assign sum       = sum_sh;
  assign cout      = cout_r;

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_r;
  assign ovf = ovf_r;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout_r <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          carry  <= c_bit;
          cnt    <= cnt + CNT_W'(1);
          if (last_bit) begin
            cout_r <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
            // On the MSB edge carry holds the carry into bit WIDTH-1.
            ovf_r  <= carry ^ c_bit;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8), including the optional ovf output.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat;
  int t_prev;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for out_valid; returns number of edges waited.
  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  // Present operands, let the next edge accept them, then wait for the result.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output int n);
    a = av;
    b = bv;
    cin = cv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(n);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    out_ready = 1'b1;
    #23;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 0x3C + 0x5A
    run_op(8'h3C, 8'h5A, 1'b0, lat);
    chk("t1_latency", lat, 8);
    chk("t1_sum", sum, 8'h96);
    chk("t1_cout", cout, 0);
    chk("t1_in_ready_done", in_ready, 0);
    @(posedge clk);
    #1;
    chk("t1_out_valid_after", out_valid, 0);
    chk("t1_in_ready_after", in_ready, 1);

    run_op(8'hFF, 8'h01, 1'b0, lat);
    chk("t2_sum", sum, 8'h00);
    chk("t2_cout", cout, 1);
    @(posedge clk);
    #1;
    run_op(8'hFF, 8'h00, 1'b1, lat);
    chk("t3_sum", sum, 8'h00);
    chk("t3_cout", cout, 1);
    @(posedge clk);
    #1;

    // Backpressure: result must hold while out_ready is low, new operands ignored
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, lat);
    chk("bp_latency", lat, 8);
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      @(posedge clk);
      #1;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum", sum, 8'h46);
      chk("bp_cout", cout, 0);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", out_valid, 0);

    // Asynchronous reset mid-shift
    a = 8'h55;
    b = 8'h0F;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_sum", sum, 0);
    chk("mid_busy_rst", busy, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(8'h01, 8'h01, 1'b0, lat);
    chk("post_rst_sum", sum, 8'h02);
    chk("post_rst_cout", cout, 0);
    @(posedge clk);
    #1;

    // Back-to-back with in_valid held high
    a = 8'h3C;
    b = 8'h5A;
    cin = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 8'hFF;
    b = 8'h01;
    wait_out(lat);
    chk("b2b0_sum", sum, 8'h96);
    t_prev = cyc;
    @(posedge clk);
    #1;
    chk("b2b_idle", in_ready, 1);
    @(posedge clk);
    #1;
    chk("b2b1_busy", busy, 1);
    a = 8'h12;
    b = 8'h34;
    wait_out(lat);
    chk("b2b1_sum", sum, 8'h00);
    chk("b2b1_cout", cout, 1);
    chk("b2b1_spacing", cyc - t_prev, 10);
    t_prev = cyc;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_out(lat);
    chk("b2b2_sum", sum, 8'h46);
    chk("b2b2_spacing", cyc - t_prev, 10);
    @(posedge clk);
    #1;

`ifdef SERIAL_ADDER_OVF_EN
    run_op(8'h7F, 8'h01, 1'b0, lat);
    chk("ovf_pos_sum", sum, 8'h80);
    chk("ovf_pos_cout", cout, 0);
    chk("ovf_pos_ovf", ovf, 1);
    @(posedge clk);
    #1;
    run_op(8'hFF, 8'h01, 1'b0, lat);
    chk("ovf_wrap_sum", sum, 8'h00);
    chk("ovf_wrap_ovf", ovf, 0);
    @(posedge clk);
    #1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
